// File: rtl/mem_stage.sv
// Memory/writeback stage: single-beat loads and stores on a req/ack port,
// one registered register-file write per ALU or load instruction, sticky timeout flag.
module mem_stage #(
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              v_i,
  input  logic [31:0]       result_i,
  input  logic [31:0]       store_data_i,
  input  logic [REG_AW-1:0] dst_i,
  input  logic              ctrl_ld_i,
  input  logic              ctrl_st_i,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              wb_en_o,
  output logic [REG_AW-1:0] wb_addr_o,
  output logic [31:0]       wb_data_o,
  output logic              err_o
);

  localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  state_t              state, state_d;
  logic [WCNT_W-1:0]   wcnt, wcnt_d;
  logic [REG_AW-1:0]   req_dst;
  logic                accept_mem;
  logic                wb_fire;
  logic [REG_AW-1:0]   wb_addr_d;
  logic [31:0]         wb_data_d;
  logic                err_set;

  // Decoded from the state register only, so reset drops the request at once.
  assign stall_o   = (state == REQ);
  assign mem_req_o = (state == REQ);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d    = state;
    wcnt_d     = wcnt;
    accept_mem = 1'b0;
    wb_fire    = 1'b0;
    wb_addr_d  = wb_addr_o;
    wb_data_d  = wb_data_o;
    err_set    = 1'b0;

    unique case (state)
      IDLE: begin
        if (v_i) begin
          if (ctrl_ld_i || ctrl_st_i) begin
            accept_mem = 1'b1;
            state_d    = REQ;
            wcnt_d     = '0;
          end else begin
            wb_fire   = (dst_i != '0);
            wb_addr_d = dst_i;
            wb_data_d = result_i;
          end
        end
      end
      REQ: begin
        // An ack in the final allowed cycle still wins over the timeout.
        if (mem_ack_i) begin
          state_d   = IDLE;
          wb_fire   = !mem_we_o && (req_dst != '0);
          wb_addr_d = req_dst;
          wb_data_d = mem_rdata_i;
        end else if (wcnt == WCNT_LAST) begin
          state_d = IDLE;
          err_set = 1'b1;
        end else begin
          wcnt_d = wcnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_d;
      wcnt  <= wcnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      req_dst     <= '0;
      wb_en_o     <= 1'b0;
      wb_addr_o   <= '0;
      wb_data_o   <= '0;
      err_o       <= 1'b0;
    end else begin
      if (accept_mem) begin
        // A simultaneous ld+st is a load.
        mem_we_o    <= ctrl_st_i && !ctrl_ld_i;
        mem_addr_o  <= result_i;
        mem_wdata_o <= store_data_i;
        req_dst     <= dst_i;
      end
      wb_en_o <= wb_fire;
      if (wb_fire) begin
        wb_addr_o <= wb_addr_d;
        wb_data_o <= wb_data_d;
      end
      if (err_set) err_o <= 1'b1;
    end
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory/writeback stage directly downstream of the execute stage. Accepts the execute result plus control bits, performs single-beat loads and stores on a request/acknowledge data-memory port, and issues one registered register-file write per completed ALU or load instruction. Back-pressures the execute stage with `stall_o` while a memory access is outstanding, and flags memory timeouts with a sticky error bit.

## Interface
- `REG_AW`, default 5: register address width.
- `TIMEOUT`, default 16: maximum number of cycles `mem_req_o` is held waiting for `mem_ack_i`; legal range 1..255.
- `clk`  input  1  clock, all state updates on the rising edge.
- `rst`  input  1  asynchronous active-low reset.
- `v_i`  input  1  execute stage presents a valid instruction.
- `result_i`  input  32  execute result: ALU value, or effective address for load/store.
- `store_data_i`  input  32  store data.
- `dst_i`  input  REG_AW  destination register.
- `ctrl_ld_i`  input  1  instruction is a load.
- `ctrl_st_i`  input  1  instruction is a store.
- `stall_o`  output  1  stage busy; upstream must hold all inputs stable.
- `mem_req_o`  output  1  memory request.
- `mem_we_o`  output  1  1 = store, 0 = load.
- `mem_addr_o`  output  32  memory address.
- `mem_wdata_o`  output  32  store data.
- `mem_ack_i`  input  1  memory completes the request this cycle.
- `mem_rdata_i`  input  32  load data, valid when `mem_ack_i`=1.
- `wb_en_o`  output  1  register-file write strobe, one-cycle pulse.
- `wb_addr_o`  output  REG_AW  write address.
- `wb_data_o`  output  32  write data.
- `err_o`  output  1  sticky memory-timeout flag.

## Operation
- States: IDLE, REQ. Wait counter `wcnt`, width sufficient for TIMEOUT.
- `stall_o` = (state == REQ), decoded from the state register, with no combinational path from the inputs.
- IDLE, `v_i`=1:
  - ALU (ld=0, st=0): next cycle `wb_en_o`=1, `wb_addr_o`=`dst_i`, `wb_data_o`=`result_i`. Stay IDLE.
  - Load or store: latch address, wdata, `dst_i`, and kind; go to REQ; `wcnt`←0.
  - ld=1 and st=1 together: treated as a load.
- IDLE, `v_i`=0: no action; `wb_en_o`=0 next cycle.
- REQ: `mem_req_o`=1. `mem_addr_o`, `mem_we_o`, and `mem_wdata_o` stay constant for the whole request.
  - `mem_ack_i`=1: go to IDLE. For a load, next cycle `wb_en_o`=1, `wb_addr_o`=latched dst, `wb_data_o`=`mem_rdata_i`. A store produces no writeback.
  - `mem_ack_i`=0 and `wcnt`==TIMEOUT−1: go to IDLE, set `err_o`=1, no writeback.
  - Otherwise: `wcnt`++.
- `v_i` is ignored while in REQ; upstream holds the instruction until `stall_o` falls.
- `mem_ack_i` is ignored outside REQ.
- Writes with `dst`==0 (ALU or load) are suppressed: `wb_en_o` stays 0.
- `err_o` is cleared only by reset. The stage keeps operating normally after an error.
- `mem_addr_o`, `mem_we_o`, and `mem_wdata_o` hold their last latched values in IDLE.
- `wb_addr_o` and `wb_data_o` hold their last values when `wb_en_o`=0.

## Timing
- Reset (asynchronous, `rst`=0): state IDLE, `wcnt`=0, and every output is 0. This covers `stall_o`, `mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `wb_en_o`, `wb_addr_o`, `wb_data_o`, and `err_o`.
- Reset during REQ: `mem_req_o` drops immediately (asynchronously); the pending load is never written back.
- ALU latency: accepted at edge N, `wb_en_o` high during cycle N+1. Throughput is one instruction per cycle.
- Memory access: accepted at edge N; `mem_req_o` and `stall_o` are high from cycle N+1.
  - If ack arrives in cycle N+k: `mem_req_o` and `stall_o` are low from N+k+1, the load writeback occurs in cycle N+k+1, and the next instruction can be accepted at edge N+k+1.
  - Minimum load latency: 2 cycles from acceptance to `wb_en_o`.
- Timeout: `mem_req_o` is held exactly TIMEOUT cycles. An ack in the TIMEOUT-th cycle counts as success. `err_o` rises in the cycle after the last request cycle.
- Back-to-back: an ALU instruction presented at edge N+k+1 (the first cycle of IDLE after an ack) writes back in N+k+2.

## Test plan
- Reset with `rst`=0 mid-stream, including while in REQ → all outputs 0 in the same cycle; after release the first ALU op writes back normally.
- ALU stream: dst 3, 4, 0, 5 with results 0x11, 0x22, 0x33, 0x44 on consecutive cycles → `wb_en_o` pulses for dst 3, 4, 5 only, with matching data; `stall_o` stays 0.
- Load, addr 0x100, dst 7, ack after 3 request cycles with rdata 0xDEADBEEF → `mem_req_o` high for 3 cycles with `mem_we_o`=0 and address stable; `stall_o` high for 3 cycles; one `wb_en_o` pulse: dst 7, data 0xDEADBEEF.
- Store, addr 0x200, data 0xCAFEF00D, ack in the first request cycle → one request cycle with `mem_we_o`=1; no `wb_en_o`; the next instruction is accepted two cycles after the store.
- Timeout, TIMEOUT=4, load never acked → `mem_req_o` high for exactly 4 cycles, then `err_o`=1 and no writeback. A later ALU op still writes back, and `err_o` stays 1.
- Edge cases:
  - Ack on the 4th request cycle with TIMEOUT=4 → success, `err_o`=0.
  - ld=1 and st=1 together → treated as a load.
  - `mem_ack_i` pulses while in IDLE → no effect on any output.
